// File: rtl/page_mem_arbiter_pkg.sv
// Shared definitions for the page memory arbiter, its interface and sub-blocks.
package page_mem_arbiter_pkg;

  localparam int unsigned PM_ADDR_W = 4;
  localparam int unsigned PM_DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } arb_state_t;

  // Ownership state for a given requester index (0 or 1).
  function automatic arb_state_t own_state(input logic side);
    return side ? ST_OWN1 : ST_OWN0;
  endfunction

endpackage

// File: rtl/page_mem_arbiter_if.sv
// Requester and memory-side bus of the page memory arbiter.
interface page_mem_arbiter_if
  import page_mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = PM_ADDR_W,
  parameter int unsigned DATA_W = PM_DATA_W
) ();

  logic              req0, req1;
  logic              lock0, lock1;
  logic              we0, we1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              gnt0, gnt1;
  logic              rvalid0, rvalid1;
  logic [DATA_W-1:0] rdata;
  logic              preempt;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic              mem_re;
  logic [DATA_W-1:0] mem_rdata;

  // Arbiter side.
  modport slave (
    input  req0, req1, lock0, lock1, we0, we1, addr0, addr1, wdata0, wdata1,
    output gnt0, gnt1, rvalid0, rvalid1, rdata, preempt,
    output mem_addr, mem_wdata, mem_we, mem_re,
    input  mem_rdata
  );

  // Requesters plus memory.
  modport master (
    output req0, req1, lock0, lock1, we0, we1, addr0, addr1, wdata0, wdata1,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata, preempt,
    input  mem_addr, mem_wdata, mem_we, mem_re,
    output mem_rdata
  );

endinterface

// File: rtl/page_mem_arbiter_hold_counter.sv
// Counts consecutive cycles a waiter spends behind a locked owner; saturating.
module arb_hold_counter #(
  parameter int unsigned W   = 4,
  parameter int unsigned SAT = 15
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_en,
  input  logic         i_clr,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  // Clear has priority; increment stops at the saturation value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != W'(SAT))) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/page_mem_arbiter.sv
// Two-requester arbiter owning the single-port page memory pins.
module page_mem_arbiter
  import page_mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W   = PM_ADDR_W,
  parameter int unsigned DATA_W   = PM_DATA_W,
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic                clk,
  input  logic                rst,
  page_mem_arbiter_if.slave   bus
);

  localparam int unsigned      HC_W      = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HC_W-1:0]  HOLD_LAST = HC_W'(MAX_HOLD - 1);

  arb_state_t        r_state, w_next;
  logic              r_last;
  logic              r_rvalid0, r_rvalid1;
  logic [HC_W-1:0]   w_hold_cnt;
  logic              w_owned, w_side;
  logic              w_own_req, w_own_lock, w_own_we, w_oth_req;
  logic              w_locked, w_hold_hit, w_xfer, w_preempt;
  logic              w_hold_en, w_hold_clr;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [DATA_W-1:0] w_mem_wdata;

  // Current owner's view of the request lines (side 1 = requester 1).
  assign w_owned    = (r_state != ST_IDLE);
  assign w_side     = (r_state == ST_OWN1);
  assign w_own_req  = w_side ? bus.req1  : bus.req0;
  assign w_own_lock = w_side ? bus.lock1 : bus.lock0;
  assign w_own_we   = w_side ? bus.we1   : bus.we0;
  assign w_oth_req  = w_side ? bus.req0  : bus.req1;
  assign w_xfer     = w_owned & w_own_req;
  assign w_locked   = w_xfer & w_own_lock;
  assign w_hold_hit = w_oth_req & (w_hold_cnt == HOLD_LAST);

  // Next owner by priority: held lock, broken lock, round-robin tie, single, idle.
  always_comb begin
    w_next    = ST_IDLE;
    w_preempt = 1'b0;
    if (w_locked && !w_hold_hit) begin
      w_next = r_state;
    end else if (w_locked) begin
      w_next    = own_state(~w_side);
      w_preempt = 1'b1;
    end else if (bus.req0 && bus.req1) begin
      w_next = own_state(~r_last);
    end else if (bus.req0) begin
      w_next = ST_OWN0;
    end else if (bus.req1) begin
      w_next = ST_OWN1;
    end
  end

  // Grant register and round-robin history.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_last  <= 1'b1;
    end else begin
      r_state <= w_next;
      if ((w_next != r_state) && (w_next != ST_IDLE)) begin
        r_last <= (w_next == ST_OWN1);
      end
    end
  end

  // Read-valid tag is captured at issue so a grant change cannot misroute it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
    end else begin
      r_rvalid0 <= w_xfer & ~w_own_we & ~w_side;
      r_rvalid1 <= w_xfer & ~w_own_we &  w_side;
    end
  end

  assign w_hold_en  = w_locked & w_oth_req;
  assign w_hold_clr = ~w_owned | ~w_oth_req | (w_next != r_state);

  arb_hold_counter #(
    .W   (HC_W),
    .SAT (MAX_HOLD - 1)
  ) u_hold (
    .clk   (clk),
    .rst   (rst),
    .i_en  (w_hold_en),
    .i_clr (w_hold_clr),
    .o_cnt (w_hold_cnt)
  );

  // Memory address/data follow the owner; driven to zero while idle.
  always_comb begin
    w_mem_addr  = '0;
    w_mem_wdata = '0;
    case (r_state)
      ST_OWN0: begin
        w_mem_addr  = bus.addr0;
        w_mem_wdata = bus.wdata0;
      end
      ST_OWN1: begin
        w_mem_addr  = bus.addr1;
        w_mem_wdata = bus.wdata1;
      end
      default: ;
    endcase
  end

  assign bus.gnt0      = (r_state == ST_OWN0);
  assign bus.gnt1      = (r_state == ST_OWN1);
  assign bus.rvalid0   = r_rvalid0;
  assign bus.rvalid1   = r_rvalid1;
  assign bus.rdata     = bus.mem_rdata;
  assign bus.preempt   = w_preempt;
  assign bus.mem_addr  = w_mem_addr;
  assign bus.mem_wdata = w_mem_wdata;
  assign bus.mem_we    = w_xfer & w_own_we;
  assign bus.mem_re    = w_xfer & ~w_own_we;

endmodule

// File: tb/tb_page_mem_arbiter.sv
// Self-checking bench for page_mem_arbiter with a behavioural arbitration model.
module tb_page_mem_arbiter;

  localparam int AW = 4;
  localparam int DW = 8;
  localparam int MH = 16;

  typedef struct packed {
    logic [1:0]         req;
    logic [1:0]         lock;
    logic [1:0]         we;
    logic [1:0][AW-1:0] addr;
    logic [1:0][DW-1:0] wdata;
  } in_t;

  typedef struct packed {
    in_t         in;
    logic [1:0]  gnt;   // {gnt1, gnt0}
    logic        re;
    logic        we;
    logic [AW-1:0] addr;
    logic [1:0]  rv;    // {rvalid1, rvalid0}
    logic [DW-1:0] rdata;
  } vec_t;

  localparam logic [DW-1:0] MEM_INIT [16] = '{
    8'h11, 8'h22, 8'h33, 8'hA5, 8'h44, 8'h5C, 8'h66, 8'h77,
    8'h81, 8'h92, 8'hA3, 8'hB4, 8'hC5, 8'hD6, 8'hE7, 8'hF8
  };

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  page_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus_if ();

  page_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_HOLD(MH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  // Page memory: synchronous write, registered read data.
  logic [DW-1:0] mem [16] = MEM_INIT;
  always @(posedge clk) begin
    if (bus_if.mem_we) mem[bus_if.mem_addr] <= bus_if.mem_wdata;
    if (bus_if.mem_re) bus_if.mem_rdata <= mem[bus_if.mem_addr];
  end

  int checks = 0;
  int failures = 0;
  int cyc_n = 0;

  logic s_g0, s_g1, s_rv0, s_rv1, s_pre, s_we, s_re;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_wd, s_rd;

  // Reference model state
  int            m_owner;   // -1 none, else requester index
  int            m_last;
  int            m_wait;
  logic [1:0]    m_rv;
  logic [DW-1:0] m_rd;
  logic [DW-1:0] m_mem [16];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc_n, got, exp);
    end
  endtask

  function automatic in_t mk(input logic [1:0] req, input logic [1:0] lock, input logic [1:0] we,
                             input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                             input logic [DW-1:0] d0, input logic [DW-1:0] d1);
    in_t r;
    r.req = req; r.lock = lock; r.we = we;
    r.addr[0] = a0; r.addr[1] = a1;
    r.wdata[0] = d0; r.wdata[1] = d1;
    return r;
  endfunction

  function automatic logic [18:0] outs();
    return {bus_if.gnt0, bus_if.gnt1, bus_if.rvalid0, bus_if.rvalid1, bus_if.preempt,
            bus_if.mem_we, bus_if.mem_re, bus_if.mem_addr, bus_if.mem_wdata};
  endfunction

  task automatic drive(input in_t x);
    bus_if.req0 = x.req[0];   bus_if.req1 = x.req[1];
    bus_if.lock0 = x.lock[0]; bus_if.lock1 = x.lock[1];
    bus_if.we0 = x.we[0];     bus_if.we1 = x.we[1];
    bus_if.addr0 = x.addr[0]; bus_if.addr1 = x.addr[1];
    bus_if.wdata0 = x.wdata[0]; bus_if.wdata1 = x.wdata[1];
  endtask

  task automatic model_reset();
    m_owner = -1; m_last = 1; m_wait = 0; m_rv = 2'b00; m_rd = '0;
  endtask

  // One cycle: called at a negedge, applies x, checks against the model, ends at next negedge.
  task automatic cyc(input in_t x);
    int o, oi, nxt;
    logic xf, we_e, re_e, locked, waiter, pre_e;
    logic [AW-1:0] a_e;
    logic [DW-1:0] d_e;
    logic [26:0] g, e;
    drive(x);
    #1;
    s_g0 = bus_if.gnt0; s_g1 = bus_if.gnt1; s_rv0 = bus_if.rvalid0; s_rv1 = bus_if.rvalid1;
    s_pre = bus_if.preempt; s_we = bus_if.mem_we; s_re = bus_if.mem_re;
    s_addr = bus_if.mem_addr; s_wd = bus_if.mem_wdata; s_rd = bus_if.rdata;
    chk("onehot_gnt", 64'(s_g0 & s_g1), 64'(0));
    chk("we_re_excl", 64'(s_we & s_re), 64'(0));
    o  = m_owner;
    oi = (o < 0) ? 0 : o;
    xf     = (o >= 0) && x.req[oi];
    we_e   = xf && x.we[oi];
    re_e   = xf && !x.we[oi];
    a_e    = (o >= 0) ? x.addr[oi] : '0;
    d_e    = (o >= 0) ? x.wdata[oi] : '0;
    locked = xf && x.lock[oi];
    waiter = (o >= 0) && x.req[1-oi];
    pre_e  = locked && waiter && (m_wait == MH - 1);
    g = {s_g0, s_g1, s_rv0, s_rv1, s_pre, s_we, s_re, s_addr, s_wd,
         (s_rv0 | s_rv1) ? s_rd : DW'(0)};
    e = {(o == 0), (o == 1), m_rv[0], m_rv[1], pre_e, we_e, re_e, a_e, d_e,
         (m_rv != 2'b00) ? m_rd : DW'(0)};
    chk("model", 64'(g), 64'(e));
    if (locked && !pre_e)             nxt = o;
    else if (pre_e)                   nxt = 1 - o;
    else if (x.req[0] && x.req[1])    nxt = 1 - m_last;
    else if (x.req[0])                nxt = 0;
    else if (x.req[1])                nxt = 1;
    else                              nxt = -1;
    if (locked && waiter && nxt == o) begin
      if (m_wait < MH - 1) m_wait++;
    end else begin
      m_wait = 0;
    end
    if (nxt >= 0 && nxt != o) m_last = nxt;
    m_rv = 2'b00;
    if (re_e) begin
      m_rv[oi] = 1'b1;
      m_rd = m_mem[a_e];
    end
    if (we_e) m_mem[a_e] = d_e;
    m_owner = nxt;
    cyc_n++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive('0);
    #2;
    chk("reset_outs", 64'(outs()), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  vec_t tbl [4];

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc_n);
    $fatal(1, "watchdog expired");
  end

  initial begin
    in_t x;
    int n0, n1, r0, r1, ng, run, max_run, last_we_c, first_g1, npre, pre_c, wrun, max_wrun;
    logic done1;
    logic [1:0] rq, lk;
    int gseq [16];

    for (int i = 0; i < 16; i++) m_mem[i] = MEM_INIT[i];
    model_reset();
    drive('0);

    // 1: reset asserted while a read is in flight
    do_reset();
    x = mk(2'b01, 2'b00, 2'b00, AW'(5), AW'(0), DW'(0), DW'(0));
    cyc(x);
    drive(x);
    #1;
    chk("t1_issue", 64'({bus_if.gnt0, bus_if.mem_re, bus_if.mem_addr}), 64'({1'b1, 1'b1, 4'd5}));
    #1 rst = 1'b1;
    #1;
    chk("t1_rst_outs", 64'(outs()), 64'(0));
    drive('0);
    #1 rst = 1'b0;
    model_reset();
    @(negedge clk);
    cyc('0);
    chk("t1_no_rvalid", 64'({s_rv0, s_rv1, s_g0, s_g1}), 64'(0));

    // 2: single requester read, table driven
    do_reset();
    tbl[0] = '{in: mk(2'b01, 2'b00, 2'b00, AW'(3), AW'(0), DW'(0), DW'(0)),
               gnt: 2'b00, re: 1'b0, we: 1'b0, addr: AW'(0), rv: 2'b00, rdata: DW'(0)};
    tbl[1] = '{in: mk(2'b01, 2'b00, 2'b00, AW'(3), AW'(0), DW'(0), DW'(0)),
               gnt: 2'b01, re: 1'b1, we: 1'b0, addr: AW'(3), rv: 2'b00, rdata: DW'(0)};
    tbl[2] = '{in: mk(2'b00, 2'b00, 2'b00, AW'(3), AW'(0), DW'(0), DW'(0)),
               gnt: 2'b01, re: 1'b0, we: 1'b0, addr: AW'(3), rv: 2'b01, rdata: 8'hA5};
    tbl[3] = '{in: '0,
               gnt: 2'b00, re: 1'b0, we: 1'b0, addr: AW'(0), rv: 2'b00, rdata: DW'(0)};
    for (int i = 0; i < 4; i++) begin
      cyc(tbl[i].in);
      chk($sformatf("t2_vec%0d", i),
          64'({s_g1, s_g0, s_re, s_we, s_addr, s_rv1, s_rv0, (s_rv0 | s_rv1) ? s_rd : DW'(0)}),
          64'({tbl[i].gnt, tbl[i].re, tbl[i].we, tbl[i].addr, tbl[i].rv, tbl[i].rdata}));
    end

    // 3: tie from idle, four reads each, alternating grants
    do_reset();
    n0 = 0; n1 = 0; r0 = 0; r1 = 0; ng = 0;
    for (int c = 0; c < 12; c++) begin
      x = mk({n1 < 4, n0 < 4}, 2'b00, 2'b00, AW'(8 + n0), AW'(12 + n1), DW'(0), DW'(0));
      cyc(x);
      if (s_rv0) begin chk("t3_rdata0", 64'(s_rd), 64'(MEM_INIT[8 + r0])); r0++; end
      if (s_rv1) begin chk("t3_rdata1", 64'(s_rd), 64'(MEM_INIT[12 + r1])); r1++; end
      if (s_g0 && x.req[0]) begin gseq[ng] = 0; ng++; n0++; end
      if (s_g1 && x.req[1]) begin gseq[ng] = 1; ng++; n1++; end
    end
    chk("t3_rv_count", 64'({r0[7:0], r1[7:0], ng[7:0]}), 64'({8'd4, 8'd4, 8'd8}));
    for (int k = 0; k < 8; k++) chk($sformatf("t3_seq%0d", k), 64'(gseq[k]), 64'(k % 2));

    // 6: grant moves to requester 1 while requester 0's read is returning
    do_reset();
    cyc(mk(2'b11, 2'b00, 2'b00, AW'(10), AW'(11), DW'(0), DW'(0)));
    cyc(mk(2'b11, 2'b00, 2'b00, AW'(10), AW'(11), DW'(0), DW'(0)));
    chk("t6_first", 64'({s_g0, s_re, s_addr}), 64'({1'b1, 1'b1, 4'd10}));
    cyc(mk(2'b10, 2'b00, 2'b00, AW'(10), AW'(11), DW'(0), DW'(0)));
    chk("t6_rv0", 64'({s_g1, s_rv0, s_rv1, s_rd}), 64'({1'b1, 1'b1, 1'b0, MEM_INIT[10]}));
    cyc('0);
    chk("t6_rv1", 64'({s_rv0, s_rv1, s_rd}), 64'({1'b0, 1'b1, MEM_INIT[11]}));

    // 4: locked 8-word burst, waiter granted right after the lock drops
    do_reset();
    n0 = 0; run = 0; max_run = 0; last_we_c = -1; first_g1 = -1; npre = 0; done1 = 1'b0;
    for (int c = 0; c < 16; c++) begin
      x = mk({(c >= 4) && !done1, n0 < 8}, {1'b0, n0 < 7}, 2'b01,
             AW'(n0), AW'(9), DW'(n0 * 3 + 1), DW'(0));
      cyc(x);
      if (s_we) begin run++; if (run > max_run) max_run = run; last_we_c = c; end
      else run = 0;
      if (s_pre) npre++;
      if (s_g0 && x.req[0]) n0++;
      if (s_g1 && first_g1 < 0) first_g1 = c;
      if (s_g1 && x.req[1]) done1 = 1'b1;
    end
    chk("t4_burst_len", 64'(max_run), 64'(8));
    chk("t4_last_we", 64'(last_we_c), 64'(8));
    chk("t4_gnt1_cycle", 64'(first_g1), 64'(9));
    chk("t4_no_preempt", 64'(npre), 64'(0));

    // 5: starvation guard breaks a long lock
    do_reset();
    npre = 0; pre_c = -1; first_g1 = -1; wrun = 0; max_wrun = 0; done1 = 1'b0;
    for (int c = 0; c < 45; c++) begin
      x = mk({(c >= 5) && !done1, c < 40}, {1'b0, c < 40}, 2'b01,
             AW'(c), AW'(2), DW'(c), DW'(0));
      cyc(x);
      if (s_pre) begin npre++; pre_c = c; end
      if (s_g1 && first_g1 < 0) first_g1 = c;
      if (x.req[1] && !s_g1) begin wrun++; if (wrun > max_wrun) max_wrun = wrun; end
      else wrun = 0;
      if (s_g1 && x.req[1]) done1 = 1'b1;
      if (c == 22) chk("t5_regain", 64'(s_g0), 64'(1));
    end
    chk("t5_preempt_cycle", 64'(pre_c), 64'(20));
    chk("t5_preempt_count", 64'(npre), 64'(1));
    chk("t5_gnt1_cycle", 64'(first_g1), 64'(21));
    chk("t5_max_wait", 64'(max_wrun), 64'(MH));

    // Randomized traffic with sticky request/lock lines
    do_reset();
    rq = 2'b00; lk = 2'b00;
    for (int c = 0; c < 2500; c++) begin
      for (int s = 0; s < 2; s++) begin
        if ($urandom_range(0, 5) == 0)  rq[s] = ~rq[s];
        if ($urandom_range(0, 11) == 0) lk[s] = ~lk[s];
      end
      x = mk(rq, lk, 2'($urandom), AW'($urandom), AW'($urandom), DW'($urandom), DW'($urandom));
      cyc(x);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
